// File: rtl/rgb_seq_pkg.sv
// Shared types and constants for the RGB fade sequencer.
//   rgb_t        : one 8-bit value per channel, packed {r,g,b}
//   seq_state_e  : sequencer FSM states
//   COLOR_TABLE  : the six-colour cycle red, yellow, green, cyan, blue, magenta
//   table_color  : safe lookup of COLOR_TABLE by a 3-bit index
//   next_index   : table index advance with wrap from 5 back to 0
package rgb_seq_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FADE = 2'd2,
        OVR  = 2'd3
    } seq_state_e;

    localparam int NUM_COLORS = 6;

    localparam rgb_t COLOR_TABLE [NUM_COLORS] = '{
        '{r: 8'hFF, g: 8'h00, b: 8'h00},   // red
        '{r: 8'hFF, g: 8'hFF, b: 8'h00},   // yellow
        '{r: 8'h00, g: 8'hFF, b: 8'h00},   // green
        '{r: 8'h00, g: 8'hFF, b: 8'hFF},   // cyan
        '{r: 8'h00, g: 8'h00, b: 8'hFF},   // blue
        '{r: 8'hFF, g: 8'h00, b: 8'hFF}    // magenta
    };

    // Indices 6 and 7 never occur; they fall back to red rather than X.
    function automatic rgb_t table_color(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = COLOR_TABLE[0];
            3'd1:    c = COLOR_TABLE[1];
            3'd2:    c = COLOR_TABLE[2];
            3'd3:    c = COLOR_TABLE[3];
            3'd4:    c = COLOR_TABLE[4];
            3'd5:    c = COLOR_TABLE[5];
            default: c = COLOR_TABLE[0];
        endcase
        return c;
    endfunction

    function automatic logic [2:0] next_index(input logic [2:0] idx);
        logic [2:0] n;
        if (idx >= 3'd5) begin
            n = 3'd0;
        end else begin
            n = idx + 3'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Three-channel PWM generator for an active-low RGB LED.
//   clk, rst_n         : clock, asynchronous active-low reset
//   target_red/green/blue : requested duty per channel
//   pin_red/green/blue : LED drive, 0 = on
// A free-running counter is compared against applied duty registers. The
// applied duties only take the requested value at the counter wrap, so a
// target change in the middle of a period never produces a short pulse.
module rgb_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] target_red,
    input  logic [PWM_BITS-1:0] target_green,
    input  logic [PWM_BITS-1:0] target_blue,
    output logic                pin_red,
    output logic                pin_green,
    output logic                pin_blue
);

    logic [PWM_BITS-1:0] cnt_r;
    logic [PWM_BITS-1:0] duty_red_r;
    logic [PWM_BITS-1:0] duty_green_r;
    logic [PWM_BITS-1:0] duty_blue_r;
    logic                wrap_s;

    // Counter is at its last value; the next edge starts a new period.
    assign wrap_s = (cnt_r == {PWM_BITS{1'b1}});

    // Free-running period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {PWM_BITS{1'b0}};
        end else begin
            cnt_r <= cnt_r + PWM_BITS'(1);
        end
    end

    // Applied duties follow the targets only at the period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_red_r   <= {PWM_BITS{1'b0}};
            duty_green_r <= {PWM_BITS{1'b0}};
            duty_blue_r  <= {PWM_BITS{1'b0}};
        end else if (wrap_s) begin
            duty_red_r   <= target_red;
            duty_green_r <= target_green;
            duty_blue_r  <= target_blue;
        end else begin
            duty_red_r   <= duty_red_r;
            duty_green_r <= duty_green_r;
            duty_blue_r  <= duty_blue_r;
        end
    end

    // Comparator inputs are all registers, so the pins cannot glitch on
    // target changes. Max duty leaves exactly one dark cycle per period.
    assign pin_red   = ~(cnt_r < duty_red_r);
    assign pin_green = ~(cnt_r < duty_green_r);
    assign pin_blue  = ~(cnt_r < duty_blue_r);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Colour sequencer for the on-board RGB LED.
//   clk, rst_n     : 12 MHz clock, asynchronous active-low reset
//   i_run          : 1 = run the colour cycle, 0 = LED off and idle
//   i_ovr_valid    : one-shot colour override request
//   i_ovr_rgb      : override duty {r,g,b}, PWM_BITS each
//   o_ovr_ready    : override accepted when valid & ready in the same cycle
//   o_color_idx    : current colour table index 0..5
//   o_fading       : high while cross-fading
//   RGB_R/G/B      : active-low LED pins
// Each table colour is held for DWELL_CYCLES, then the target duties walk one
// step every FADE_TICK cycles toward the next colour. An accepted override
// shows its colour for DWELL_CYCLES and then fades back to the current table
// colour without advancing the index.
module rgb_fade_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int DWELL_CYCLES = 2000000,
    parameter int FADE_TICK    = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_run,
    input  logic                  i_ovr_valid,
    input  logic [3*PWM_BITS-1:0] i_ovr_rgb,
    output logic                  o_ovr_ready,
    output logic [2:0]            o_color_idx,
    output logic                  o_fading,
    output logic                  RGB_R,
    output logic                  RGB_G,
    output logic                  RGB_B
);

    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int TICK_W  = (FADE_TICK > 1) ? $clog2(FADE_TICK) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(FADE_TICK - 1);

    typedef logic [PWM_BITS-1:0] duty_t;

    // The table holds only fully-off or fully-on channels, so any non-zero
    // entry maps to maximum duty regardless of PWM resolution.
    function automatic duty_t expand(input logic [7:0] c);
        duty_t d;
        if (c != 8'h00) begin
            d = {PWM_BITS{1'b1}};
        end else begin
            d = {PWM_BITS{1'b0}};
        end
        return d;
    endfunction

    // One unit toward the goal; equal values stay put, so no overshoot.
    function automatic duty_t step_toward(input duty_t cur, input duty_t goal);
        duty_t n;
        if (cur < goal) begin
            n = cur + PWM_BITS'(1);
        end else if (cur > goal) begin
            n = cur - PWM_BITS'(1);
        end else begin
            n = cur;
        end
        return n;
    endfunction

    seq_state_e         state_r,   state_nx_s;
    logic [2:0]         idx_r,     idx_nx_s;
    duty_t              red_r,     red_nx_s;
    duty_t              green_r,   green_nx_s;
    duty_t              blue_r,    blue_nx_s;
    logic [DWELL_W-1:0] dwell_r,   dwell_nx_s;
    logic [TICK_W-1:0]  tick_r,    tick_nx_s;

    rgb_t  goal_s;
    rgb_t  first_s;
    duty_t goal_red_s, goal_green_s, goal_blue_s;
    duty_t step_red_s, step_green_s, step_blue_s;
    duty_t ovr_red_s,  ovr_green_s,  ovr_blue_s;
    logic  ready_s;
    logic  accept_s;

    assign goal_s       = table_color(idx_r);
    assign first_s      = table_color(3'd0);
    assign goal_red_s   = expand(goal_s.r);
    assign goal_green_s = expand(goal_s.g);
    assign goal_blue_s  = expand(goal_s.b);

    assign step_red_s   = step_toward(red_r,   goal_red_s);
    assign step_green_s = step_toward(green_r, goal_green_s);
    assign step_blue_s  = step_toward(blue_r,  goal_blue_s);

    assign ovr_red_s    = i_ovr_rgb[3*PWM_BITS-1 -: PWM_BITS];
    assign ovr_green_s  = i_ovr_rgb[2*PWM_BITS-1 -: PWM_BITS];
    assign ovr_blue_s   = i_ovr_rgb[PWM_BITS-1:0];

    assign ready_s  = i_run & ((state_r == HOLD) | (state_r == FADE));
    assign accept_s = i_ovr_valid & ready_s;

    // Next-state, target and counter update. Stop beats override, which
    // beats dwell expiry, so an accept on the expiry cycle keeps the index.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        red_nx_s   = red_r;
        green_nx_s = green_r;
        blue_nx_s  = blue_r;
        dwell_nx_s = dwell_r;
        tick_nx_s  = tick_r;
        if (!i_run) begin
            state_nx_s = IDLE;
            red_nx_s   = {PWM_BITS{1'b0}};
            green_nx_s = {PWM_BITS{1'b0}};
            blue_nx_s  = {PWM_BITS{1'b0}};
            dwell_nx_s = {DWELL_W{1'b0}};
            tick_nx_s  = {TICK_W{1'b0}};
        end else if (accept_s) begin
            state_nx_s = OVR;
            red_nx_s   = ovr_red_s;
            green_nx_s = ovr_green_s;
            blue_nx_s  = ovr_blue_s;
            dwell_nx_s = {DWELL_W{1'b0}};
            tick_nx_s  = {TICK_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    state_nx_s = HOLD;
                    idx_nx_s   = 3'd0;
                    red_nx_s   = expand(first_s.r);
                    green_nx_s = expand(first_s.g);
                    blue_nx_s  = expand(first_s.b);
                    dwell_nx_s = {DWELL_W{1'b0}};
                end
                HOLD: begin
                    if (dwell_r == DWELL_LAST) begin
                        state_nx_s = FADE;
                        idx_nx_s   = next_index(idx_r);
                        dwell_nx_s = {DWELL_W{1'b0}};
                        tick_nx_s  = {TICK_W{1'b0}};
                    end else begin
                        dwell_nx_s = dwell_r + DWELL_W'(1);
                    end
                end
                FADE: begin
                    if (tick_r == TICK_LAST) begin
                        tick_nx_s  = {TICK_W{1'b0}};
                        red_nx_s   = step_red_s;
                        green_nx_s = step_green_s;
                        blue_nx_s  = step_blue_s;
                    end else begin
                        tick_nx_s  = tick_r + TICK_W'(1);
                    end
                    // Leave on the same edge as the final step so the fade
                    // takes exactly FADE_TICK cycles per unit of distance.
                    if ((red_nx_s == goal_red_s) && (green_nx_s == goal_green_s) &&
                        (blue_nx_s == goal_blue_s)) begin
                        state_nx_s = HOLD;
                        dwell_nx_s = {DWELL_W{1'b0}};
                    end else begin
                        state_nx_s = FADE;
                    end
                end
                OVR: begin
                    if (dwell_r == DWELL_LAST) begin
                        state_nx_s = FADE;
                        dwell_nx_s = {DWELL_W{1'b0}};
                        tick_nx_s  = {TICK_W{1'b0}};
                    end else begin
                        dwell_nx_s = dwell_r + DWELL_W'(1);
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    red_nx_s   = {PWM_BITS{1'b0}};
                    green_nx_s = {PWM_BITS{1'b0}};
                    blue_nx_s  = {PWM_BITS{1'b0}};
                    dwell_nx_s = {DWELL_W{1'b0}};
                    tick_nx_s  = {TICK_W{1'b0}};
                end
            endcase
        end
    end

    // Sequencer state, index, fade targets and timers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= 3'd0;
            red_r   <= {PWM_BITS{1'b0}};
            green_r <= {PWM_BITS{1'b0}};
            blue_r  <= {PWM_BITS{1'b0}};
            dwell_r <= {DWELL_W{1'b0}};
            tick_r  <= {TICK_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            red_r   <= red_nx_s;
            green_r <= green_nx_s;
            blue_r  <= blue_nx_s;
            dwell_r <= dwell_nx_s;
            tick_r  <= tick_nx_s;
        end
    end

    assign o_ovr_ready = ready_s;
    assign o_color_idx = idx_r;
    assign o_fading    = (state_r == FADE);

    rgb_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk          (clk),
        .rst_n        (rst_n),
        .target_red   (red_r),
        .target_green (green_r),
        .target_blue  (blue_r),
        .pin_red      (RGB_R),
        .pin_green    (RGB_G),
        .pin_blue     (RGB_B)
    );

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with short dwell/fade parameters.
// Expectations are queued with exp() and compared by check_all() at a
// negedge. The bench keeps its own PWM phase (posedges since reset release,
// mod 256) to align override timing and full-period pin measurements.
module tb_rgb_fade_sequencer;

    localparam int PWM_BITS  = 8;
    localparam int DWELL     = 100;
    localparam int FADE_TICK = 2;

    localparam int SEL_IDX    = 0;
    localparam int SEL_FADING = 1;
    localparam int SEL_READY  = 2;
    localparam int SEL_R      = 3;
    localparam int SEL_G      = 4;
    localparam int SEL_B      = 5;
    localparam int SEL_LOW_R  = 6;
    localparam int SEL_LOW_G  = 7;
    localparam int SEL_LOW_B  = 8;
    localparam int SEL_WAITED = 9;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  i_run = 1'b0;
    logic                  i_ovr_valid = 1'b0;
    logic [3*PWM_BITS-1:0] i_ovr_rgb = '0;
    logic                  o_ovr_ready;
    logic [2:0]            o_color_idx;
    logic                  o_fading;
    logic                  RGB_R, RGB_G, RGB_B;

    int checks = 0;
    int errors = 0;
    int phase = 0;
    int low_r = 0, low_g = 0, low_b = 0;
    int waited = 0;

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;
    exp_t sb[$];

    rgb_fade_sequencer #(
        .PWM_BITS     (PWM_BITS),
        .DWELL_CYCLES (DWELL),
        .FADE_TICK    (FADE_TICK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_run       (i_run),
        .i_ovr_valid (i_ovr_valid),
        .i_ovr_rgb   (i_ovr_rgb),
        .o_ovr_ready (o_ovr_ready),
        .o_color_idx (o_color_idx),
        .o_fading    (o_fading),
        .RGB_R       (RGB_R),
        .RGB_G       (RGB_G),
        .RGB_B       (RGB_B)
    );

    always #5 clk = ~clk;

    // Expected PWM counter value: free-running from 0 after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= 0;
        else        phase <= (phase + 1) % 256;
    end

    function automatic int obs(input int sel);
        int v;
        case (sel)
            SEL_IDX:    v = int'(o_color_idx);
            SEL_FADING: v = int'(o_fading);
            SEL_READY:  v = int'(o_ovr_ready);
            SEL_R:      v = int'(RGB_R);
            SEL_G:      v = int'(RGB_G);
            SEL_B:      v = int'(RGB_B);
            SEL_LOW_R:  v = low_r;
            SEL_LOW_G:  v = low_g;
            SEL_LOW_B:  v = low_b;
            SEL_WAITED: v = waited;
            default:    v = -1;
        endcase
        return v;
    endfunction

    task automatic exp(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        int   o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.val);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int v);
        do @(negedge clk); while (phase != v);
    endtask

    task automatic wait_idx(input int v, input int budget);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while ((int'(o_color_idx) != v) && (waited < budget));
        checks++;
        assert (int'(o_color_idx) == v) else begin
            errors++;
            $error("FAIL wait_idx_%0d: observed idx %0d expected %0d within %0d cycles",
                   v, o_color_idx, v, budget);
        end
    endtask

    // Count low (lit) cycles per pin over one full 256-cycle PWM period.
    task automatic measure();
        low_r = 0;
        low_g = 0;
        low_b = 0;
        for (int i = 0; i < 256; i++) begin
            if (RGB_R == 1'b0) low_r++;
            if (RGB_G == 1'b0) low_g++;
            if (RGB_B == 1'b0) low_b++;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        cycles(2);
        exp("rst_r", SEL_R, 1); exp("rst_g", SEL_G, 1); exp("rst_b", SEL_B, 1);
        exp("rst_idx", SEL_IDX, 0); exp("rst_fading", SEL_FADING, 0);
        exp("rst_ready", SEL_READY, 0);
        check_all();
        rst_n = 1'b1;
        cycles(5);
        exp("idle_r", SEL_R, 1); exp("idle_ready", SEL_READY, 0);
        check_all();

        // Start: 100-cycle hold of red, then fade to yellow with idx 1
        i_run = 1'b1;
        cycles(100);
        exp("hold_end_fading", SEL_FADING, 0); exp("hold_end_idx", SEL_IDX, 0);
        exp("hold_ready", SEL_READY, 1);
        check_all();
        cycles(1);
        exp("fade1_fading", SEL_FADING, 1); exp("fade1_idx", SEL_IDX, 1);
        check_all();
        cycles(160);
        measure();
        exp("red_low_r", SEL_LOW_R, 255); exp("red_low_b", SEL_LOW_B, 0);
        check_all();

        // Red->yellow fade lasts 510 cycles, then a 100-cycle hold
        cycles(93);
        exp("fade1_last", SEL_FADING, 1);
        check_all();
        cycles(1);
        exp("fade1_done", SEL_FADING, 0); exp("fade1_done_idx", SEL_IDX, 1);
        check_all();
        cycles(99);
        exp("hold2_last", SEL_FADING, 0);
        check_all();
        cycles(1);
        exp("fade2_fading", SEL_FADING, 1); exp("fade2_idx", SEL_IDX, 2);
        check_all();

        // Index wraps 5 -> 0, one colour every 610 cycles
        wait_idx(5, 3000);
        wait_idx(0, 1000);
        exp("wrap_period", SEL_WAITED, 610); exp("wrap_fading", SEL_FADING, 1);
        check_all();

        // Stop together with an override request: not accepted, LED goes dark
        i_run = 1'b0;
        i_ovr_valid = 1'b1;
        i_ovr_rgb = 24'h0000FF;
        #1;
        exp("stop_ready", SEL_READY, 0);
        check_all();
        cycles(1);
        exp("stop_fading", SEL_FADING, 0); exp("stop_ready_idle", SEL_READY, 0);
        check_all();
        wait_phase(0);
        measure();
        exp("dark_low_r", SEL_LOW_R, 0); exp("dark_low_g", SEL_LOW_G, 0);
        exp("dark_low_b", SEL_LOW_B, 0);
        check_all();
        i_ovr_valid = 1'b0;

        // Restart at a known PWM phase; accept a blue override in HOLD
        wait_phase(190);
        i_run = 1'b1;
        cycles(10);
        exp("ovr_ready", SEL_READY, 1); exp("ovr_pre_fading", SEL_FADING, 0);
        exp("ovr_pre_idx", SEL_IDX, 0);
        check_all();
        i_ovr_valid = 1'b1;
        i_ovr_rgb = 24'h0000FF;
        cycles(1);
        exp("ovr_busy_ready", SEL_READY, 0); exp("ovr_fading", SEL_FADING, 0);
        exp("ovr_idx", SEL_IDX, 0);
        check_all();
        i_ovr_valid = 1'b0;
        // The period after the next wrap shows blue throughout, even though
        // the targets start fading back mid-period.
        wait_phase(0);
        measure();
        exp("blue_low_r", SEL_LOW_R, 0); exp("blue_low_g", SEL_LOW_G, 0);
        exp("blue_low_b", SEL_LOW_B, 255);
        check_all();
        exp("back_fading", SEL_FADING, 1); exp("back_idx", SEL_IDX, 0);
        check_all();
        cycles(298);
        exp("back_last", SEL_FADING, 1);
        check_all();
        cycles(1);
        exp("back_done", SEL_FADING, 0); exp("back_done_idx", SEL_IDX, 0);
        check_all();

        // Accept on the dwell-expiry cycle: OVR wins, index stays 0
        cycles(99);
        exp("exp_ready", SEL_READY, 1); exp("exp_fading", SEL_FADING, 0);
        check_all();
        i_ovr_valid = 1'b1;
        i_ovr_rgb = 24'h00FF00;
        cycles(1);
        exp("coll_fading", SEL_FADING, 0); exp("coll_idx", SEL_IDX, 0);
        exp("coll_ready", SEL_READY, 0);
        check_all();
        i_ovr_valid = 1'b0;
        cycles(99);
        exp("coll_ovr_last", SEL_FADING, 0);
        check_all();
        cycles(1);
        exp("coll_fade", SEL_FADING, 1); exp("coll_fade_idx", SEL_IDX, 0);
        check_all();

        // Asynchronous reset in the middle of a fade
        wait_idx(1, 2000);
        cycles(50);
        exp("pre_rst_ready", SEL_READY, 1); exp("pre_rst_fading", SEL_FADING, 1);
        check_all();
        rst_n = 1'b0;
        #1;
        exp("arst_r", SEL_R, 1); exp("arst_g", SEL_G, 1); exp("arst_b", SEL_B, 1);
        exp("arst_idx", SEL_IDX, 0); exp("arst_fading", SEL_FADING, 0);
        exp("arst_ready", SEL_READY, 0);
        check_all();
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
